platform_row_renderer: RTL

PLATFORM_ROW_RENDERER -- requirements
Module: platform_row_renderer

---
 rtl/platform_row_renderer.sv | 111 +++++++++++
 1 files changed

// File: rtl/platform_row_renderer.sv
// Renders one horizontal platform: a 16-pixel sprite row repeated TILES times,
// fetched from a combinational sprite ROM once per visible line.
module platform_row_renderer #(
  parameter int SPRITE_BASE = 0,
  parameter int ROWS        = 4,
  parameter int TILES       = 8
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        frame_start,
  input  logic [9:0]  plat_x,
  input  logic [9:0]  plat_y,
  input  logic        line_start,
  input  logic [9:0]  draw_y,
  input  logic        pixel_en,
  output logic [10:0] rom_addr,
  input  logic [15:0] rom_data,
  output logic        pixel_on,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, FETCH, WAIT, DRAW} state_t;

  state_t      state_q, state_d;
  logic [9:0]  px_reg, py_reg, x_cnt;
  logic [15:0] row_reg, shift_reg;
  logic [3:0]  bit_cnt;
  logic [5:0]  tile_cnt;

  logic [9:0]  row;
  logic        row_hit;
  logic        x_match;
  logic        last_pix;

  always_comb begin
    // Subtraction in 10 bits gives the intended vertical wrap mod 1024.
    row      = draw_y - py_reg;
    row_hit  = ({22'd0, row} < 32'(ROWS));
    x_match  = (x_cnt == px_reg);
    last_pix = (bit_cnt == 4'd15) && (tile_cnt == 6'(TILES - 1));
    state_d  = state_q;
    if (frame_start) begin
      state_d = IDLE;
    end else if (line_start) begin
      state_d = row_hit ? FETCH : IDLE;
    end else begin
      case (state_q)
        FETCH:   state_d = WAIT;
        WAIT:    if (x_match) state_d = DRAW;
        DRAW:    if (pixel_en && last_pix) state_d = IDLE;
        default: state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      px_reg    <= '0;
      py_reg    <= '0;
      x_cnt     <= '0;
      row_reg   <= '0;
      shift_reg <= '0;
      bit_cnt   <= '0;
      tile_cnt  <= '0;
      rom_addr  <= 11'(SPRITE_BASE);
    end else begin
      if (line_start)                           x_cnt <= '0;
      else if (pixel_en && (x_cnt != 10'd1023)) x_cnt <= x_cnt + 10'd1;

      if (frame_start) begin
        px_reg <= plat_x;
        py_reg <= plat_y;
      end else if (line_start) begin
        if (row_hit) rom_addr <= 11'(SPRITE_BASE) + 11'(row);
      end else begin
        case (state_q)
          FETCH: row_reg <= rom_data;
          WAIT: begin
            if (x_match) begin
              shift_reg <= row_reg;
              bit_cnt   <= '0;
              tile_cnt  <= '0;
            end
          end
          DRAW: begin
            if (pixel_en) begin
              bit_cnt <= bit_cnt + 4'd1;
              // End of a tile: restart the pattern rather than shifting in zeros.
              if (bit_cnt == 4'd15) begin
                shift_reg <= row_reg;
                tile_cnt  <= tile_cnt + 6'd1;
              end else begin
                shift_reg <= shift_reg << 1;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign pixel_on = (state_q == DRAW) && shift_reg[15];
  assign busy     = (state_q != IDLE);

endmodule
